// File: rtl/control_decode_stage.sv
// Registered RV32 opcode decode stage with a two-entry skid buffer.
// o_ready is a flop and leaves the stage at full throughput. Illegal opcodes are counted on retire.
module control_decode_stage #(
    parameter int PCW     = 32,
    parameter bit EN_JALR = 1'b1,
    parameter int CNTW    = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [PCW-1:0]  i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_inst,
    output logic [PCW-1:0]  o_pc,
    output logic [10:0]     o_ctrl,
    output logic [5:0]      o_format,
    output logic            o_illegal,
    output logic [CNTW-1:0] o_illegal_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]    inst;
        logic [PCW-1:0] pc;
        logic [10:0]    ctrl;
        logic [5:0]     fmt;
        logic           illegal;
    } entry_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            dec_branch;
    logic            dec_mem_rd;
    logic            dec_mem_to_reg;
    logic            dec_mem_wr;
    logic            dec_alu_src;
    logic            dec_reg_wr;
    logic            dec_jump;
    logic [1:0]      dec_alu_op;
    logic            dec_lui;
    logic            dec_jalr;
    logic [5:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;

    logic            accept;
    logic            retire;

    // Opcode decode of the incoming word; format one-hot is {J,U,B,S,I,R}.
    always_comb begin
        dec_branch     = 1'b0;
        dec_mem_rd     = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_wr     = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_wr     = 1'b0;
        dec_jump       = 1'b0;
        dec_alu_op     = 2'b00;
        dec_lui        = 1'b0;
        dec_jalr       = 1'b0;
        dec_fmt        = 6'b000000;
        dec_illegal    = 1'b0;
        case (i_inst[6:0])
            7'b0110011: begin
                dec_reg_wr = 1'b1;
                dec_alu_op = 2'b10;
                dec_fmt    = 6'b000001;
            end
            7'b0010011: begin
                dec_alu_src = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_alu_op  = 2'b11;
                dec_fmt     = 6'b000010;
            end
            7'b0000011: begin
                dec_mem_rd     = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_reg_wr     = 1'b1;
                dec_fmt        = 6'b000010;
            end
            7'b0100011: begin
                dec_mem_wr  = 1'b1;
                dec_alu_src = 1'b1;
                dec_fmt     = 6'b000100;
            end
            7'b1100011: begin
                dec_branch = 1'b1;
                dec_alu_op = 2'b01;
                dec_fmt    = 6'b001000;
            end
            7'b0110111: begin
                dec_alu_src = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_alu_op  = 2'b11;
                dec_lui     = 1'b1;
                dec_fmt     = 6'b010000;
            end
            7'b0010111: begin
                dec_alu_src = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_fmt     = 6'b010000;
            end
            7'b1101111: begin
                dec_alu_src = 1'b1;
                dec_reg_wr  = 1'b1;
                dec_jump    = 1'b1;
                dec_fmt     = 6'b100000;
            end
            7'b1100111: begin
                if (EN_JALR) begin
                    dec_alu_src = 1'b1;
                    dec_reg_wr  = 1'b1;
                    dec_jump    = 1'b1;
                    dec_jalr    = 1'b1;
                    dec_fmt     = 6'b000010;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_entry.inst    = i_inst;
        dec_entry.pc      = i_pc;
        dec_entry.ctrl    = {dec_jalr, dec_lui, dec_alu_op, dec_jump, dec_reg_wr,
                             dec_alu_src, dec_mem_wr, dec_mem_to_reg, dec_mem_rd, dec_branch};
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
    end

    assign accept = i_valid & ready_q;
    assign retire = (state_q != EMPTY) & i_ready;

    // Skid control: main always feeds the outputs, and skid holds the entry that arrived while stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            if (retire && main_q.illegal && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = dec_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && !retire) begin
                        skid_d  = dec_entry;
                        state_d = TWO;
                    end else if (accept && retire) begin
                        main_d  = dec_entry;
                        state_d = ONE;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (retire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid       = (state_q != EMPTY);
    assign o_ready       = ready_q;
    assign o_inst        = main_q.inst;
    assign o_pc          = main_q.pc;
    assign o_ctrl        = main_q.ctrl;
    assign o_format      = main_q.fmt;
    assign o_illegal     = main_q.illegal;
    assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_control_decode_stage.sv
// Scoreboard bench for control_decode_stage: one default instance and one with CNTW=2 and EN_JALR=0, both driven from shared inputs.
module tb_control_decode_stage;

   localparam logic [31:0] ADD   = 32'h00B50533;
   localparam logic [31:0] ADDI  = 32'h00150513;
   localparam logic [31:0] LW    = 32'h0005A283;
   localparam logic [31:0] SW    = 32'h0055A023;
   localparam logic [31:0] BEQ   = 32'h00B50463;
   localparam logic [31:0] LUI   = 32'h123452B7;
   localparam logic [31:0] AUIPC = 32'h00001297;
   localparam logic [31:0] JAL   = 32'h008000EF;
   localparam logic [31:0] JALR  = 32'h000080E7;
   localparam logic [31:0] BAD   = 32'h0000007F;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        inValid;
   logic [31:0] inInst;
   logic [31:0] inPc;
   logic        outReady;

   logic        o_ready, o_valid, o_illegal;
   logic [31:0] o_inst, o_pc;
   logic [10:0] o_ctrl;
   logic [5:0]  o_format;
   logic [7:0]  o_illegal_cnt;

   logic        o2_ready, o2_valid, o2_illegal;
   logic [31:0] o2_inst, o2_pc;
   logic [10:0] o2_ctrl;
   logic [5:0]  o2_format;
   logic [1:0]  o2_illegal_cnt;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [10:0] ctrl;
      logic [5:0]  fmt;
      logic        ill;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   nChecks = 0;
   int   nFail = 0;
   bit   modelReady;
   int   cnt1, cnt2;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clock = ~clock;

   control_decode_stage #(.PCW(32), .EN_JALR(1'b1), .CNTW(8)) dut (
      .i_clk(clock), .i_rst(reset), .i_flush(flush), .i_valid(inValid), .o_ready(o_ready),
      .i_inst(inInst), .i_pc(inPc), .o_valid(o_valid), .i_ready(outReady),
      .o_inst(o_inst), .o_pc(o_pc), .o_ctrl(o_ctrl), .o_format(o_format),
      .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
   );

   control_decode_stage #(.PCW(32), .EN_JALR(1'b0), .CNTW(2)) dut2 (
      .i_clk(clock), .i_rst(reset), .i_flush(flush), .i_valid(inValid), .o_ready(o2_ready),
      .i_inst(inInst), .i_pc(inPc), .o_valid(o2_valid), .i_ready(outReady),
      .o_inst(o2_inst), .o_pc(o2_pc), .o_ctrl(o2_ctrl), .o_format(o2_format),
      .o_illegal(o2_illegal), .o_illegal_cnt(o2_illegal_cnt)
   );

   // Reference decode table; ctrl order is {jalr,lui,aluOp,jump,regWr,aluSrc,memWr,memToReg,memRd,branch}.
   function automatic exp_t expectOf(input logic [31:0] inst, input logic [31:0] pc, input bit enJalr);
      exp_t e;
      e.inst = inst;
      e.pc   = pc;
      e.ill  = 1'b0;
      case (inst[6:0])
         7'h33: begin e.ctrl = 11'b0_0_10_0_1_0_0_0_0_0; e.fmt = 6'b000001; end
         7'h13: begin e.ctrl = 11'b0_0_11_0_1_1_0_0_0_0; e.fmt = 6'b000010; end
         7'h03: begin e.ctrl = 11'b0_0_00_0_1_1_0_1_1_0; e.fmt = 6'b000010; end
         7'h23: begin e.ctrl = 11'b0_0_00_0_0_1_1_0_0_0; e.fmt = 6'b000100; end
         7'h63: begin e.ctrl = 11'b0_0_01_0_0_0_0_0_0_1; e.fmt = 6'b001000; end
         7'h37: begin e.ctrl = 11'b0_1_11_0_1_1_0_0_0_0; e.fmt = 6'b010000; end
         7'h17: begin e.ctrl = 11'b0_0_00_0_1_1_0_0_0_0; e.fmt = 6'b010000; end
         7'h6F: begin e.ctrl = 11'b0_0_00_1_1_1_0_0_0_0; e.fmt = 6'b100000; end
         7'h67: begin
            if (enJalr) begin
               e.ctrl = 11'b1_0_00_1_1_1_0_0_0_0; e.fmt = 6'b000010;
            end else begin
               e.ctrl = 11'b0; e.fmt = 6'b0; e.ill = 1'b1;
            end
         end
         default: begin e.ctrl = 11'b0; e.fmt = 6'b0; e.ill = 1'b1; end
      endcase
      return e;
   endfunction

   // One assertion per comparison; failures are counted and reported with both values.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic compareEntry(input string tag, input exp_t e, input logic [31:0] inst,
                               input logic [31:0] pc, input logic [10:0] ctrl,
                               input logic [5:0] fmt, input logic ill);
      checkOutput({tag, "_inst"}, inst, e.inst);
      checkOutput({tag, "_pc"}, pc, e.pc);
      checkOutput({tag, "_ctrl"}, {21'b0, ctrl}, {21'b0, e.ctrl});
      checkOutput({tag, "_fmt"}, {26'b0, fmt}, {26'b0, e.fmt});
      checkOutput({tag, "_illegal"}, {31'b0, ill}, {31'b0, e.ill});
   endtask

   // Drives one cycle, checks both instances mid-cycle against the model, and then advances the model across the edge.
   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input logic rdy, input logic fl);
      bit   doRetire;
      exp_t e1, e2;
      inValid  = v;
      inInst   = inst;
      inPc     = pc;
      outReady = rdy;
      flush    = fl;
      @(negedge clock);
      checkOutput("valid", {31'b0, o_valid}, {31'b0, q1.size() > 0});
      checkOutput("ready", {31'b0, o_ready}, {31'b0, modelReady});
      checkOutput("valid2", {31'b0, o2_valid}, {31'b0, q2.size() > 0});
      checkOutput("ready2", {31'b0, o2_ready}, {31'b0, modelReady});
      checkOutput("cnt", {24'b0, o_illegal_cnt}, cnt1);
      checkOutput("cnt2", {30'b0, o2_illegal_cnt}, cnt2);
      doRetire = (q1.size() > 0) && rdy && !fl;
      if (doRetire) begin
         e1 = q1.pop_front();
         e2 = q2.pop_front();
         compareEntry("out", e1, o_inst, o_pc, o_ctrl, o_format, o_illegal);
         compareEntry("out2", e2, o2_inst, o2_pc, o2_ctrl, o2_format, o2_illegal);
         if (e1.ill && cnt1 < 255) cnt1++;
         if (e2.ill && cnt2 < 3) cnt2++;
      end
      if (fl) begin
         q1.delete();
         q2.delete();
      end else if (v && modelReady) begin
         q1.push_back(expectOf(inst, pc, 1'b1));
         q2.push_back(expectOf(inst, pc, 1'b0));
      end
      modelReady = (q1.size() < 2);
      @(posedge clock);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
      checkOutput({tag, "_ready"}, {31'b0, o_ready}, 32'd1);
      checkOutput({tag, "_inst"}, o_inst, 32'd0);
      checkOutput({tag, "_pc"}, o_pc, 32'd0);
      checkOutput({tag, "_ctrl"}, {21'b0, o_ctrl}, 32'd0);
      checkOutput({tag, "_fmt"}, {26'b0, o_format}, 32'd0);
      checkOutput({tag, "_illegal"}, {31'b0, o_illegal}, 32'd0);
      checkOutput({tag, "_cnt"}, {24'b0, o_illegal_cnt}, 32'd0);
      checkOutput({tag, "_valid2"}, {31'b0, o2_valid}, 32'd0);
      checkOutput({tag, "_cnt2"}, {30'b0, o2_illegal_cnt}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      inValid = 1'b0;
      inInst = 32'h0;
      inPc = 32'h0;
      outReady = 1'b0;
      modelReady = 1'b1;
      cnt1 = 0;
      cnt2 = 0;

      @(negedge clock);
      checkResetValues("rst");
      reset = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] single ADD");
      applyStimulus(1'b1, ADD, 32'h100, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] back-to-back stream");
      applyStimulus(1'b1, LW,    32'h200, 1'b1, 1'b0);
      applyStimulus(1'b1, SW,    32'h204, 1'b1, 1'b0);
      applyStimulus(1'b1, BEQ,   32'h208, 1'b1, 1'b0);
      applyStimulus(1'b1, LUI,   32'h20C, 1'b1, 1'b0);
      applyStimulus(1'b1, AUIPC, 32'h210, 1'b1, 1'b0);
      applyStimulus(1'b1, JAL,   32'h214, 1'b1, 1'b0);
      applyStimulus(1'b1, JALR,  32'h218, 1'b1, 1'b0);
      applyStimulus(1'b1, ADDI,  32'h21C, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] stall fill and drain");
      applyStimulus(1'b1, ADD,  32'h300, 1'b0, 1'b0);
      applyStimulus(1'b1, LW,   32'h304, 1'b0, 1'b0);
      checkOutput("t3_ready_low", {31'b0, o_ready}, 32'd0);
      applyStimulus(1'b1, SW,   32'h308, 1'b0, 1'b0);
      applyStimulus(1'b1, SW,   32'h308, 1'b1, 1'b0);
      applyStimulus(1'b1, SW,   32'h308, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] flush while full");
      applyStimulus(1'b1, BEQ,  32'h400, 1'b0, 1'b0);
      applyStimulus(1'b1, BAD,  32'h404, 1'b0, 1'b0);
      applyStimulus(1'b1, JAL,  32'h408, 1'b0, 1'b1);
      checkOutput("t4_valid", {31'b0, o_valid}, 32'd0);
      checkOutput("t4_ready", {31'b0, o_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] illegal opcodes and counter saturation");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, BAD, 32'h500 + 32'(4 * i), 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("t5_cnt2_sat", {30'b0, o2_illegal_cnt}, 32'd3);
      applyStimulus(1'b1, JALR, 32'h600, 1'b1, 1'b0);
      checkOutput("t5_jalr_illegal2", {31'b0, o2_illegal}, 32'd1);
      checkOutput("t5_jalr_legal", {31'b0, o_illegal}, 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] asynchronous reset during stall");
      applyStimulus(1'b1, LUI, 32'h700, 1'b0, 1'b0);
      applyStimulus(1'b1, ADD, 32'h704, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkResetValues("async");
      q1.delete();
      q2.delete();
      cnt1 = 0;
      cnt2 = 0;
      modelReady = 1'b1;
      #2;
      reset = 1'b0;
      inValid = 1'b0;
      @(posedge clock);
      #1;
      applyStimulus(1'b1, AUIPC, 32'h800, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
